// File: rtl/dec_pkg.sv
// Shared types and elaboration helpers for the decoder pointer sequencer.
//   seq_state_t       : sequencer FSM states
//   min_ptr_width()   : smallest pointer width able to address dec_w channels
//   ptr_width_ok()    : true when a ptr_w-bit pointer covers dec_w channels
package dec_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      ISSUE = 1'b1
   } seq_state_t;

   // Smallest pointer width for dec_w channels (at least one bit).
   function automatic int unsigned min_ptr_width(input int unsigned dec_w);
      return (dec_w <= 1) ? 1 : $clog2(dec_w);
   endfunction

   // Pointer range check: 2**ptr_w >= dec_w.
   function automatic bit ptr_width_ok(input int unsigned ptr_w, input int unsigned dec_w);
      return ptr_w >= min_ptr_width(dec_w);
   endfunction

endpackage

// File: rtl/dec_find_next.sv
// Combinational search for the lowest set mask bit at or above a start index.
//   mask     in  DEC_BIT_WIDTH  candidate channels
//   from_idx in  PTR_BIT_WIDTH  search start index
//   incl     in  1              1: include from_idx itself, 0: strictly above it
//   found    out 1              a candidate exists
//   idx      out PTR_BIT_WIDTH  lowest qualifying index (0 when none found)
module dec_find_next #(
   parameter int unsigned PTR_BIT_WIDTH = 3,
   parameter int unsigned DEC_BIT_WIDTH = 8
) (
   input  logic [DEC_BIT_WIDTH-1:0] mask,
   input  logic [PTR_BIT_WIDTH-1:0] from_idx,
   input  logic                     incl,
   output logic                     found,
   output logic [PTR_BIT_WIDTH-1:0] idx
);

   logic [31:0] from_ext;

   assign from_ext = 32'(from_idx);

   // Scan from the top down so the last hit is the lowest qualifying index.
   always_comb begin
      found = 1'b0;
      idx   = '0;
      for (int unsigned i = DEC_BIT_WIDTH; i > 0; i--) begin
         if (mask[i-1] && ((32'(i-1) > from_ext) || (incl && (32'(i-1) == from_ext)))) begin
            found = 1'b1;
            idx   = PTR_BIT_WIDTH'(i-1);
         end
      end
   end

endmodule

// File: rtl/dec_ptr_sequencer.sv
// Pointer source for the one-hot / one-to-N decoders: walks the channels
// enabled in a captured mask, lowest first, with a VALID/READY handshake.
//   clk, rst_n  clock (rising edge), async active-low reset
//   start       pulse: capture mask/cont and begin a scan (ignored while busy)
//   stop        pulse: end the scan at the next handshake
//   cont        wrap-around scanning, sampled with start
//   mask        channel enables, sampled with start
//   ready       consumer accepts ptr when valid & ready
//   ptr         current channel index (registered)
//   valid       ptr valid (registered)
//   busy        scan in progress; identical to valid
//   done        one-cycle pulse when a pass over the enabled channels completes
module dec_ptr_sequencer
   import dec_pkg::*;
#(
   parameter int unsigned PTR_BIT_WIDTH = 3,
   parameter int unsigned DEC_BIT_WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start,
   input  logic                     stop,
   input  logic                     cont,
   input  logic [DEC_BIT_WIDTH-1:0] mask,
   input  logic                     ready,
   output logic [PTR_BIT_WIDTH-1:0] ptr,
   output logic                     valid,
   output logic                     busy,
   output logic                     done
);

   if (!ptr_width_ok(PTR_BIT_WIDTH, DEC_BIT_WIDTH)) begin : g_width_check
      $error("dec_ptr_sequencer: PTR_BIT_WIDTH cannot address DEC_BIT_WIDTH channels");
   end

   seq_state_t               state_q, state_d;
   logic [PTR_BIT_WIDTH-1:0] ptr_q, ptr_d;
   logic [DEC_BIT_WIDTH-1:0] mask_q, mask_d;
   logic                     cont_q, cont_d;
   logic                     stop_q, stop_d;
   logic                     done_q, done_d;

   logic [DEC_BIT_WIDTH-1:0] first_src;
   logic                     first_found, next_found;
   logic [PTR_BIT_WIDTH-1:0] first_idx, next_idx;

   // Launch searches the live mask; wrap-around searches the captured one.
   assign first_src = (state_q == IDLE) ? mask : mask_q;

   dec_find_next #(
      .PTR_BIT_WIDTH (PTR_BIT_WIDTH),
      .DEC_BIT_WIDTH (DEC_BIT_WIDTH)
   ) u_find_first (
      .mask     (first_src),
      .from_idx ('0),
      .incl     (1'b1),
      .found    (first_found),
      .idx      (first_idx)
   );

   dec_find_next #(
      .PTR_BIT_WIDTH (PTR_BIT_WIDTH),
      .DEC_BIT_WIDTH (DEC_BIT_WIDTH)
   ) u_find_next (
      .mask     (mask_q),
      .from_idx (ptr_q),
      .incl     (1'b0),
      .found    (next_found),
      .idx      (next_idx)
   );

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         mask_q  <= '0;
         cont_q  <= 1'b0;
         stop_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         mask_q  <= mask_d;
         cont_q  <= cont_d;
         stop_q  <= stop_d;
         done_q  <= done_d;
      end
   end

   // Next-state and output logic.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      mask_d  = mask_q;
      cont_d  = cont_q;
      stop_d  = stop_q;
      done_d  = 1'b0;

      unique case (state_q)
         IDLE: begin
            // A simultaneous stop cancels the launch.
            if (start && !stop) begin
               mask_d = mask;
               cont_d = cont;
               stop_d = 1'b0;
               if (first_found) begin
                  state_d = ISSUE;
                  ptr_d   = first_idx;
               end else begin
                  done_d = 1'b1;
               end
            end
         end

         ISSUE: begin
            if (ready) begin
               if (stop_q || stop) begin
                  // Graceful stop: end on this handshake without a done pulse.
                  state_d = IDLE;
                  stop_d  = 1'b0;
               end else if (next_found) begin
                  ptr_d = next_idx;
               end else begin
                  done_d = 1'b1;
                  if (cont_q) begin
                     ptr_d = first_idx;
                  end else begin
                     state_d = IDLE;
                  end
               end
            end else if (stop) begin
               stop_d = 1'b1;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   assign ptr   = ptr_q;
   assign valid = (state_q == ISSUE);
   assign busy  = (state_q == ISSUE);
   assign done  = done_q;

endmodule

// File: tb/tb_dec_ptr_sequencer.sv
// Self-checking bench for dec_ptr_sequencer: directed vector table,
// hand-written reset sequence, and random stimulus against a list-based model.
module tb_dec_ptr_sequencer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start, stop, cont, ready;
   logic [7:0] mask;
   logic [2:0] ptr;
   logic       valid, busy, done;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   dec_ptr_sequencer #(
      .PTR_BIT_WIDTH (3),
      .DEC_BIT_WIDTH (8)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .stop  (stop),
      .cont  (cont),
      .mask  (mask),
      .ready (ready),
      .ptr   (ptr),
      .valid (valid),
      .busy  (busy),
      .done  (done)
   );

   typedef struct {
      logic       start;
      logic       stop;
      logic       cont;
      logic [7:0] mask;
      logic       ready;
      int         exp_ptr;
      logic       exp_valid;
      logic       exp_done;
   } vec_t;

   vec_t vecs[$];

   // Model state: the list of enabled indices for the active scan.
   int   m_list[$];
   int   m_pos;
   int   m_ptr;
   bit   m_valid, m_cont, m_stop, m_done;

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
   endtask

   task automatic chk_outs(input string tag, input int e_ptr, input bit e_valid, input bit e_done);
      chk({tag, " ptr"},   int'(ptr),   e_ptr);
      chk({tag, " valid"}, int'(valid), int'(e_valid));
      chk({tag, " busy"},  int'(busy),  int'(e_valid));
      chk({tag, " done"},  int'(done),  int'(e_done));
   endtask

   task automatic drive(input bit s, input bit p, input bit c, input logic [7:0] m, input bit r);
      start = s; stop = p; cont = c; mask = m; ready = r;
   endtask

   // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      m_list.delete();
      m_pos = 0; m_ptr = 0; m_valid = 0; m_cont = 0; m_stop = 0; m_done = 0;
   endtask

   // Behaviour of one clock edge, expressed over the list of enabled channels.
   task automatic model_step(input bit s, input bit p, input bit c, input logic [7:0] m, input bit r);
      int lst[$];
      m_done = 0;
      if (!m_valid) begin
         if (s && !p) begin
            for (int i = 0; i < 8; i++) if (m[i]) lst.push_back(i);
            if (lst.size() == 0) m_done = 1;
            else begin
               m_list = lst; m_pos = 0; m_ptr = lst[0];
               m_valid = 1; m_cont = c; m_stop = 0;
            end
         end
      end else if (r) begin
         if (m_stop || p) begin
            m_valid = 0; m_stop = 0;
         end else if (m_pos + 1 < m_list.size()) begin
            m_pos++; m_ptr = m_list[m_pos];
         end else begin
            m_done = 1;
            if (m_cont) begin m_pos = 0; m_ptr = m_list[0]; end
            else m_valid = 0;
         end
      end else if (p) begin
         m_stop = 1;
      end
   endtask

   function automatic vec_t mk(input bit s, input bit p, input bit c, input logic [7:0] m,
                               input bit r, input int ep, input bit ev, input bit ed);
      vec_t v;
      v.start = s; v.stop = p; v.cont = c; v.mask = m; v.ready = r;
      v.exp_ptr = ep; v.exp_valid = ev; v.exp_done = ed;
      return v;
   endfunction

   initial begin
      // Scan of 1010_0101, single shot, ready held high.
      vecs.push_back(mk(1,0,0,8'hA5,1, 0,1,0));
      vecs.push_back(mk(0,0,0,8'h00,1, 2,1,0));
      vecs.push_back(mk(0,0,0,8'h00,1, 5,1,0));
      vecs.push_back(mk(0,0,0,8'h00,1, 7,1,0));
      vecs.push_back(mk(0,0,0,8'h00,1, 7,0,1));
      vecs.push_back(mk(0,0,0,8'h00,1, 7,0,0));
      // Empty mask: done after one cycle, never valid.
      vecs.push_back(mk(1,0,0,8'h00,1, 7,0,1));
      vecs.push_back(mk(0,0,0,8'h00,1, 7,0,0));
      // Mask/start changes during a scan of 8'h81 have no effect.
      vecs.push_back(mk(1,0,0,8'h81,0, 0,1,0));
      vecs.push_back(mk(1,0,1,8'hFF,0, 0,1,0));
      vecs.push_back(mk(1,0,1,8'hFF,1, 7,1,0));
      vecs.push_back(mk(1,0,1,8'hFF,1, 7,0,1));
      vecs.push_back(mk(0,0,0,8'h00,0, 7,0,0));
      // Stop while stalled on index 2; ends at the next handshake, no done.
      vecs.push_back(mk(1,0,1,8'hA5,1, 0,1,0));
      vecs.push_back(mk(0,0,0,8'h00,1, 2,1,0));
      vecs.push_back(mk(0,1,0,8'h00,0, 2,1,0));
      vecs.push_back(mk(0,0,0,8'h00,0, 2,1,0));
      vecs.push_back(mk(0,0,0,8'h00,0, 2,1,0));
      vecs.push_back(mk(0,0,0,8'h00,1, 2,0,0));
      vecs.push_back(mk(0,0,0,8'h00,1, 2,0,0));
      // Start and stop together while idle: nothing happens.
      vecs.push_back(mk(1,1,0,8'hA5,1, 2,0,0));
      // Continuous 0001_0010 with ready toggling.
      vecs.push_back(mk(1,0,1,8'h12,0, 1,1,0));
      vecs.push_back(mk(0,0,0,8'h00,1, 4,1,0));
      vecs.push_back(mk(0,0,0,8'h00,0, 4,1,0));
      vecs.push_back(mk(0,0,0,8'h00,1, 1,1,1));
      vecs.push_back(mk(0,0,0,8'h00,0, 1,1,0));
      vecs.push_back(mk(0,0,0,8'h00,1, 4,1,0));
      vecs.push_back(mk(0,0,0,8'h00,1, 1,1,1));
      vecs.push_back(mk(0,1,0,8'h00,1, 1,0,0));
      // Single channel, continuous: same index every fire, done every fire, stop on it.
      vecs.push_back(mk(1,0,1,8'h08,1, 3,1,0));
      vecs.push_back(mk(0,0,0,8'h00,1, 3,1,1));
      vecs.push_back(mk(0,0,0,8'h00,1, 3,1,1));
      vecs.push_back(mk(0,1,0,8'h00,1, 3,0,0));

      // Reset state.
      drive(0,0,0,8'h00,0);
      rst_n = 1'b0;
      #12;
      chk_outs("reset", 0, 0, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // Directed vector table.
      foreach (vecs[i]) begin
         drive(vecs[i].start, vecs[i].stop, vecs[i].cont, vecs[i].mask, vecs[i].ready);
         tick();
         chk_outs($sformatf("vec%0d", i), vecs[i].exp_ptr, vecs[i].exp_valid, vecs[i].exp_done);
      end

      // Asynchronous reset in the middle of a scan.
      drive(1,0,1,8'hF0,0);
      tick();
      drive(0,0,0,8'h00,1);
      tick();
      chk_outs("pre_rst", 5, 1, 0);
      #2;
      rst_n = 1'b0;
      #1;
      chk_outs("async_rst", 0, 0, 0);
      tick();
      rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk_outs("post_rst_idle", 0, 0, 0);
      end
      drive(1,0,0,8'h40,1);
      tick();
      chk_outs("post_rst_start", 6, 1, 0);
      drive(0,0,0,8'h00,1);
      tick();
      chk_outs("post_rst_end", 6, 0, 1);

      // Random stimulus against the model, from a fresh reset.
      rst_n = 1'b0;
      #1;
      model_reset();
      tick();
      rst_n = 1'b1;
      for (int n = 0; n < 3000; n++) begin
         bit         s, p, c, r;
         logic [7:0] m;
         s = ($urandom_range(3) == 0);
         p = ($urandom_range(15) == 0);
         c = $urandom_range(1) == 1;
         r = $urandom_range(2) != 0;
         case ($urandom_range(5))
            0:       m = 8'h00;
            1:       m = 8'(1 << $urandom_range(7));
            default: m = 8'($urandom);
         endcase
         drive(s, p, c, m, r);
         model_step(s, p, c, m, r);
         tick();
         chk_outs("rand", m_ptr, m_valid, m_done);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
